// File: rtl/rv32i_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32i_bus_pkg                                                    |
// | RV32I data-bus encodings, UART register map and TX FSM states.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rv32i_bus_pkg;

    localparam logic [2:0] c_st_sb  = 3'b000;
    localparam logic [2:0] c_st_sh  = 3'b001;
    localparam logic [2:0] c_st_sw  = 3'b010;

    localparam logic [2:0] c_ld_lb  = 3'b000;
    localparam logic [2:0] c_ld_lh  = 3'b001;
    localparam logic [2:0] c_ld_lw  = 3'b010;
    localparam logic [2:0] c_ld_lbu = 3'b100;
    localparam logic [2:0] c_ld_lhu = 3'b101;

    localparam logic [1:0] c_reg_txdata  = 2'd0;
    localparam logic [1:0] c_reg_status  = 2'd1;
    localparam logic [1:0] c_reg_bauddiv = 2'd2;
    localparam logic [1:0] c_reg_ctrl    = 2'd3;

    localparam int c_stat_busy      = 0;
    localparam int c_stat_full      = 1;
    localparam int c_stat_empty     = 2;
    localparam int c_stat_ovf       = 3;
    localparam int c_stat_count_lsb = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Byte/half loads take the lane at the byte offset, then extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  ltype);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (ltype)
            c_ld_lb:  result = {{24{shifted[7]}}, shifted[7:0]};
            c_ld_lh:  result = {{16{shifted[15]}}, shifted[15:0]};
            c_ld_lw:  result = word;
            c_ld_lbu: result = {24'd0, shifted[7:0]};
            c_ld_lhu: result = {16'd0, shifted[15:0]};
            default:  result = 32'd0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo                                                        |
// | Single-clock FIFO, registered storage, combinational head output.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full_cnt = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full/empty are judged on the pre-edge count, so a push into a full
    // FIFO is dropped even if a pop happens on the same edge.
    assign full      = (r_count == c_full_cnt);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_mmio                                                     |
// | Memory-mapped 8N1 UART transmitter with TX FIFO and baud divider.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_mmio
    import rv32i_bus_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic        d_wr_en,
    input  logic [2:0]  store_type,
    input  logic [2:0]  load_type,
    output logic [31:0] dRdata,
    output logic        tx
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]      w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_cw-1:0] w_fifo_count;

    logic [15:0]     r_bauddiv;
    logic            r_en;
    logic            r_ovf;

    tx_state_t       r_state;
    tx_state_t       w_state_next;
    logic            w_pop;
    logic            w_baud_done;
    logic [15:0]     r_div;
    logic [15:0]     r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    logic            w_wr;
    logic [1:0]      w_reg;
    logic            w_push;
    logic            w_busy;
    logic [31:0]     w_status;
    logic [31:0]     w_word;
    logic            w_unused;

    assign w_wr     = sel && d_wr_en;
    assign w_reg    = dAddr[3:2];
    assign w_push   = w_wr && (w_reg == c_reg_txdata);
    assign w_unused = ^{dAddr[31:4], dWdata[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (dWdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bauddiv <= DEFAULT_DIV;
            r_en      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_wr) begin
            case (w_reg)
                c_reg_txdata: begin
                    if (w_fifo_full) begin
                        r_ovf <= 1'b1;
                    end
                end
                c_reg_status: begin
                    if (dWdata[c_stat_ovf]) begin
                        r_ovf <= 1'b0;
                    end
                end
                c_reg_bauddiv: begin
                    case (store_type)
                        c_st_sw: r_bauddiv <= dWdata[15:0];
                        c_st_sh: begin
                            if (!dAddr[1]) begin
                                r_bauddiv <= dWdata[15:0];
                            end
                        end
                        c_st_sb: begin
                            if (dAddr[1:0] == 2'd0) begin
                                r_bauddiv[7:0] <= dWdata[7:0];
                            end else if (dAddr[1:0] == 2'd1) begin
                                r_bauddiv[15:8] <= dWdata[7:0];
                            end
                        end
                        default: ;
                    endcase
                end
                default: begin
                    // CTRL: only stores that cover byte lane 0 reach EN.
                    case (store_type)
                        c_st_sw: r_en <= dWdata[0];
                        c_st_sh: begin
                            if (!dAddr[1]) begin
                                r_en <= dWdata[0];
                            end
                        end
                        c_st_sb: begin
                            if (dAddr[1:0] == 2'd0) begin
                                r_en <= dWdata[0];
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign w_baud_done = (r_baud_cnt == (r_div - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_en && !w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The divider is captured at the pop so a BAUDDIV write only affects
    // the next frame; a zero divider is run as one clock per bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div      <= 16'd1;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else if (w_pop) begin
            r_div      <= (r_bauddiv == 16'd0) ? 16'd1 : r_bauddiv;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= w_fifo_dout;
        end else if (r_state != ST_IDLE) begin
            if (w_baud_done) begin
                r_baud_cnt <= 16'd0;
                if (r_state == ST_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (r_state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = r_shift[0];
            default:  tx = 1'b1;
        endcase
    end

    assign w_busy = (r_state != ST_IDLE) || !w_fifo_empty;

    always_comb begin
        w_status                          = 32'd0;
        w_status[c_stat_busy]             = w_busy;
        w_status[c_stat_full]             = w_fifo_full;
        w_status[c_stat_empty]            = w_fifo_empty;
        w_status[c_stat_ovf]              = r_ovf;
        w_status[c_stat_count_lsb +: 8]   = 8'(w_fifo_count);
    end

    always_comb begin
        case (w_reg)
            c_reg_status:  w_word = w_status;
            c_reg_bauddiv: w_word = {16'd0, r_bauddiv};
            c_reg_ctrl:    w_word = {31'd0, r_en};
            default:       w_word = 32'd0;
        endcase
    end

    assign dRdata = sel ? load_extend(w_word, dAddr[1:0], load_type) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_mmio                                                  |
// | Self-checking bench: register table, frame timing, random frames.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_tx_mmio;

    localparam int          c_depth = 8;
    localparam int          c_hist  = 40000;
    localparam logic [2:0]  c_sb = 3'b000, c_sh = 3'b001, c_sw = 3'b010;
    localparam logic [2:0]  c_lb = 3'b000, c_lh = 3'b001, c_lw = 3'b010;
    localparam logic [2:0]  c_lbu = 3'b100, c_lhu = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        d_wr_en;
    logic [2:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] dRdata;
    logic        tx;

    uart_tx_mmio #(
        .FIFO_DEPTH  (c_depth),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .dAddr      (dAddr),
        .dWdata     (dWdata),
        .d_wr_en    (d_wr_en),
        .store_type (store_type),
        .load_type  (load_type),
        .dRdata     (dRdata),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic tx_hist [c_hist];
    int   n_err = 0;
    int   n_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < c_hist) tx_hist[cyc] = tx;

    initial begin
        #600000;
        $display("FAIL watchdog: time bound exceeded, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        bit          s;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [23];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input bit s, input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] st, output int edge_no);
        sel = s; d_wr_en = 1'b1; dAddr = addr; dWdata = data; store_type = st;
        @(posedge clk); #1;
        edge_no = cyc;
        sel = 1'b0; d_wr_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] st);
        int e;
        bus_write(1'b1, addr, data, st, e);
    endtask

    task automatic bus_read(input bit s, input logic [31:0] addr, input logic [2:0] lt,
                            output logic [31:0] v);
        sel = s; d_wr_en = 1'b0; dAddr = addr; load_type = lt;
        #2;
        v = dRdata;
        sel = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [2:0] lt,
                            input logic [31:0] exp);
        logic [31:0] v;
        bus_read(1'b1, addr, lt, v);
        check32(name, v, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status(input int size, input bit ovf, input bit fsm_busy);
        logic [31:0] v;
        v        = 32'd0;
        v[0]     = fsm_busy || (size > 0);
        v[1]     = (size == c_depth);
        v[2]     = (size == 0);
        v[3]     = ovf;
        v[15:8]  = 8'(size);
        return v;
    endfunction

    // Expected line level for offset i from the start of a frame of 10 bit periods.
    function automatic logic frame_bit(input logic [7:0] b, input int i, input int d);
        int k;
        if (i < 0 || i >= 10 * d) return 1'b1;
        k = i / d;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic check_frame(input string name, input int start, input logic [7:0] b, input int d);
        int   target;
        bit   bad;
        int   bad_i;
        logic got;
        target = start + 10 * d + 1;
        while (cyc < target) begin @(posedge clk); #1; end
        bad = 0; bad_i = 0;
        for (int i = -1; i <= 10 * d; i++) begin
            if (!bad && tx_hist[start + i] !== frame_bit(b, i, d)) begin
                bad = 1; bad_i = i;
            end
        end
        n_chk++;
        if (bad) begin
            n_err++;
            got = tx_hist[start + bad_i];
            $display("FAIL %s: byte 0x%02h div %0d offset %0d tx=%b expected %b",
                     name, b, d, bad_i, got, frame_bit(b, bad_i, d));
        end
    endtask

    task automatic check_high(input string name, input int from, input int n);
        int bad_i;
        while (cyc < from + n) begin @(posedge clk); #1; end
        bad_i = -1;
        for (int i = 0; i < n; i++) begin
            if (bad_i < 0 && tx_hist[from + i] !== 1'b1) bad_i = i;
        end
        n_chk++;
        if (bad_i >= 0) begin
            n_err++;
            $display("FAIL %s: tx=%b at cycle %0d expected 1", name, tx_hist[from + bad_i], from + bad_i);
        end
    endtask

    logic [7:0]  q [$];
    bit          ovf_m;
    int          e, s, r, dv, de, n;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] v, rnd;

    initial begin
        vecs[0]  = '{1, 1, 32'h8, c_sw,   32'h0000_80F0, 32'h0,          "set_div_80f0"};
        vecs[1]  = '{0, 1, 32'h8, c_lb,   32'h0,         32'hFFFF_FFF0,  "lb_08"};
        vecs[2]  = '{0, 1, 32'h8, c_lbu,  32'h0,         32'h0000_00F0,  "lbu_08"};
        vecs[3]  = '{0, 1, 32'h8, c_lh,   32'h0,         32'hFFFF_80F0,  "lh_08"};
        vecs[4]  = '{0, 1, 32'h8, c_lhu,  32'h0,         32'h0000_80F0,  "lhu_08"};
        vecs[5]  = '{0, 1, 32'h9, c_lb,   32'h0,         32'hFFFF_FF80,  "lb_09"};
        vecs[6]  = '{0, 1, 32'h9, c_lbu,  32'h0,         32'h0000_0080,  "lbu_09"};
        vecs[7]  = '{0, 1, 32'h8, c_lw,   32'h0,         32'h0000_80F0,  "lw_08"};
        vecs[8]  = '{0, 1, 32'hA, c_lb,   32'h0,         32'h0,          "lb_0a_upper"};
        vecs[9]  = '{0, 1, 32'h8, 3'b011, 32'h0,         32'h0,          "undef_load"};
        vecs[10] = '{0, 0, 32'h8, c_lw,   32'h0,         32'h0,          "sel0_read"};
        vecs[11] = '{1, 1, 32'h9, c_sb,   32'h1212_1212, 32'h0,          "sb_lane1"};
        vecs[12] = '{0, 1, 32'h8, c_lw,   32'h0,         32'h0000_12F0,  "after_sb_lane1"};
        vecs[13] = '{1, 1, 32'hA, c_sh,   32'hBEEF_BEEF, 32'h0,          "sh_upper_ignored"};
        vecs[14] = '{1, 1, 32'hB, c_sb,   32'h7777_7777, 32'h0,          "sb_lane3_ignored"};
        vecs[15] = '{0, 1, 32'h8, c_lw,   32'h0,         32'h0000_12F0,  "after_ignored"};
        vecs[16] = '{1, 1, 32'h8, c_sh,   32'hABCD_0004, 32'h0,          "sh_lower"};
        vecs[17] = '{0, 1, 32'h8, c_lhu,  32'h0,         32'h0000_0004,  "after_sh"};
        vecs[18] = '{1, 0, 32'h8, c_sw,   32'h0000_FFFF, 32'h0,          "sel0_write"};
        vecs[19] = '{0, 1, 32'h8, c_lw,   32'h0,         32'h0000_0004,  "after_sel0_write"};
        vecs[20] = '{0, 1, 32'h0, c_lw,   32'h0,         32'h0,          "txdata_reads_0"};
        vecs[21] = '{0, 1, 32'hC, c_lw,   32'h0,         32'h0,          "ctrl_off"};
        vecs[22] = '{0, 1, 32'h4, c_lw,   32'h0,         32'h0000_0004,  "status_idle"};

        reset = 1'b1; sel = 1'b0; d_wr_en = 1'b0; dAddr = 32'd0; dWdata = 32'd0;
        store_type = 3'd0; load_type = 3'd0;
        tick(3);
        reset = 1'b0;

        // Reset state
        check32("reset_tx", {31'd0, tx}, 32'd1);
        rd_check("reset_status", 32'h4, c_lw, 32'h0000_0004);
        rd_check("reset_bauddiv", 32'h8, c_lw, 32'd868);
        rd_check("reset_ctrl", 32'hC, c_lw, 32'd0);
        check_high("reset_tx_line", 1, 6);

        // Single frame, push into empty FIFO while enabled
        wr(32'h8, 32'd4, c_sw);
        wr(32'hC, 32'd1, c_sw);
        bus_write(1'b1, 32'h0, 32'h0000_0055, c_sb, e);
        rd_check("t2_status_queued", 32'h4, c_lw, exp_status(1, 0, 0));
        rd_check("t2_status_popped", 32'h4, c_lw, exp_status(0, 0, 1));
        check_frame("t2_frame_55", e + 1, 8'h55, 4);

        // Fill past full, overflow, push during the pop edge, drain
        wr(32'hC, 32'd0, c_sw);
        q.delete(); ovf_m = 0;
        for (int i = 0; i < 9; i++) begin
            rnd = $urandom;
            wr(32'h0, rnd, c_sw);
            if (q.size() < c_depth) q.push_back(rnd[7:0]); else ovf_m = 1;
        end
        rd_check("t3_status_full", 32'h4, c_lw, exp_status(q.size(), ovf_m, 0));
        wr(32'h4, 32'h8, c_sw);
        ovf_m = 0;
        rd_check("t3_ovf_clear", 32'h4, c_lw, exp_status(q.size(), ovf_m, 0));
        bus_write(1'b1, 32'hC, 32'd1, c_sw, e);
        wr(32'h0, $urandom, c_sb);
        ovf_m = 1;
        rd_check("t3_push_at_pop_edge", 32'h4, c_lw, exp_status(q.size() - 1, ovf_m, 1));
        for (int k = 0; k < q.size(); k++)
            check_frame($sformatf("t3_frame%0d", k), e + 1 + k * 41, q[k], 4);
        check_high("t3_no_extra_frame", e + 1 + q.size() * 41 - 1, 30);
        rd_check("t3_drained", 32'h4, c_lw, exp_status(0, 1, 0));
        wr(32'h4, 32'h8, c_sw);
        wr(32'hC, 32'd0, c_sw);

        // Register map and load extension table
        for (int i = 0; i < $size(vecs); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].s, vecs[i].addr, vecs[i].wdata, vecs[i].typ, e);
            end else begin
                bus_read(vecs[i].s, vecs[i].addr, vecs[i].typ, v);
                check32(vecs[i].name, v, vecs[i].exp);
            end
        end

        // BAUDDIV written mid-frame applies to the next frame only
        b0 = 8'($urandom); b1 = 8'($urandom);
        wr(32'h0, {24'd0, b0}, c_sb);
        wr(32'h0, {24'd0, b1}, c_sb);
        bus_write(1'b1, 32'hC, 32'd1, c_sw, e);
        s = e + 1;
        tick(15);
        wr(32'h8, 32'd3, c_sw);
        check_frame("t5_old_div", s, b0, 4);
        check_frame("t5_new_div", s + 41, b1, 3);

        // EN cleared mid-frame: frame finishes, queue holds
        wr(32'hC, 32'd0, c_sw);
        wr(32'h8, 32'd4, c_sw);
        b2 = 8'($urandom); b3 = 8'($urandom);
        wr(32'h0, {24'd0, b2}, c_sb);
        wr(32'h0, {24'd0, b3}, c_sb);
        bus_write(1'b1, 32'hC, 32'd1, c_sw, e);
        s = e + 1;
        tick(10);
        wr(32'hC, 32'd0, c_sw);
        check_frame("t5_en_off_frame", s, b2, 4);
        check_high("t5_en_off_idle", s + 40, 50);
        rd_check("t5_count_kept", 32'h4, c_lw, exp_status(1, 0, 0));

        // Reset during DATA with three bytes still queued
        for (int i = 0; i < 3; i++) wr(32'h0, $urandom, c_sw);
        bus_write(1'b1, 32'hC, 32'd1, c_sw, e);
        tick(12);
        reset = 1'b1;
        tick(1);
        r = cyc;
        reset = 1'b0;
        check32("t6_tx_after_reset", {31'd0, tx}, 32'd1);
        rd_check("t6_status", 32'h4, c_lw, exp_status(0, 0, 0));
        rd_check("t6_ctrl", 32'hC, c_lw, 32'd0);
        rd_check("t6_bauddiv", 32'h8, c_lw, 32'd868);
        check_high("t6_line_idle", r, 40);

        // Randomised bursts against the queue model
        for (int it = 0; it < 6; it++) begin
            dv = (it == 0) ? 0 : $urandom_range(1, 6);
            de = (dv == 0) ? 1 : dv;
            n  = $urandom_range(1, 10);
            wr(32'h4, 32'h8, c_sw);
            wr(32'h8, dv, c_sw);
            q.delete(); ovf_m = 0;
            for (int i = 0; i < n; i++) begin
                rnd = $urandom;
                wr({30'd0, 2'($urandom_range(0, 3))}, rnd, 3'($urandom_range(0, 2)));
                if (q.size() < c_depth) q.push_back(rnd[7:0]); else ovf_m = 1;
            end
            rd_check($sformatf("rnd%0d_status", it), 32'h4, c_lw, exp_status(q.size(), ovf_m, 0));
            rd_check($sformatf("rnd%0d_div", it), 32'h8, c_lw, dv);
            bus_write(1'b1, 32'hC, 32'd1, c_sw, e);
            for (int k = 0; k < q.size(); k++)
                check_frame($sformatf("rnd%0d_frame%0d", it, k), e + 1 + k * (10 * de + 1), q[k], de);
            wr(32'hC, 32'd0, c_sw);
            rd_check($sformatf("rnd%0d_done", it), 32'h4, c_lw, exp_status(0, ovf_m, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
